// File: rtl/systolic_os_if.sv
// Operand and result bus for the output-stationary systolic GEMM engine.
// The master side (operand buffers / writeback) drives the job control, the
// operand beats and c_ready. The slave side (the array) drives the rest.
interface systolic_os_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DW    = 8,
    parameter int K_MAX = 64,
    parameter int KW    = $clog2(K_MAX) + 1,
    parameter int ACCW  = 2 * DW + $clog2(K_MAX),
    parameter int RW    = $clog2(ROWS)
) ();
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 a_valid;
    logic                 a_ready;
    logic [ROWS*DW-1:0]   a_data;
    logic [COLS*DW-1:0]   b_data;
    logic                 c_valid;
    logic                 c_ready;
    logic [COLS*ACCW-1:0] c_data;
    logic [RW-1:0]        c_row;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, a_valid, a_data, b_data, c_ready,
        input  a_ready, c_valid, c_data, c_row, busy, done
    );

    modport slave (
        input  start, k_len, a_valid, a_data, b_data, c_ready,
        output a_ready, c_valid, c_data, c_row, busy, done
    );
endinterface

// File: rtl/systolic_os_array.sv
// Output-stationary systolic GEMM engine: C[ROWS][COLS] = A[ROWS][K] x B[K][COLS].
// A columns / B rows enter as one beat per step through stall-aware input
// skew; each cell accumulates in place, the array is drained with zero
// operands and C is read out one row at a time.
// Handshakes: a beat transfers on a rising edge where a_valid && a_ready; a
// result row transfers on a rising edge where c_valid && c_ready; c_data and
// c_row hold while c_valid && !c_ready.
// Optional feature macro SYSTOLIC_RELU_EN: clamps each output lane to max(acc,0).
module systolic_os_array #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DW    = 8,
    parameter int K_MAX = 64,
    parameter int KW    = $clog2(K_MAX) + 1,
    parameter int ACCW  = 2 * DW + $clog2(K_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    systolic_os_if.slave       bus,
    output logic [2:0]         state_dbg
);
    localparam int RW  = $clog2(ROWS);
    localparam int DCW = $clog2(ROWS + COLS);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS + COLS - 2);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic [KW-1:0]  K_CAP      = KW'(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t          state;
    logic            a_ready_q;
    logic            c_valid_q;
    logic            busy_q;
    logic            done_q;
    logic [RW-1:0]   row;
    logic [KW-1:0]   kcnt;
    logic [KW-1:0]   klen_q;
    logic [DCW-1:0]  dcnt;
    logic [KW-1:0]   k_eff;
    logic            adv;
    logic            clr;

    logic signed [DW-1:0]   inj_a  [ROWS];
    logic signed [DW-1:0]   inj_b  [COLS];
    logic signed [DW-1:0]   edge_a [ROWS];
    logic signed [DW-1:0]   edge_b [COLS];
    logic signed [DW-1:0]   a_in   [ROWS][COLS];
    logic signed [DW-1:0]   b_in   [ROWS][COLS];
    logic signed [DW-1:0]   a_pipe [ROWS][COLS-1];
    logic signed [DW-1:0]   b_pipe [ROWS-1][COLS];
    logic signed [ACCW-1:0] acc    [ROWS][COLS];
    logic signed [ACCW-1:0] lane_val;
    logic [COLS*ACCW-1:0]   c_data_w;

    // Sign-extended product of one operand pair.
    function automatic logic signed [ACCW-1:0] mac_term(input logic signed [DW-1:0] a,
                                                        input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return {{(ACCW - 2 * DW){p[2*DW-1]}}, p};
    endfunction

    assign k_eff = (bus.k_len > K_CAP) ? K_CAP : bus.k_len;
    // The whole array moves only on an accepted beat or a drain step.
    assign adv   = (bus.a_valid && a_ready_q) || (state == S_DRAIN);
    assign clr   = (state == S_IDLE) && bus.start;

    assign bus.a_ready = a_ready_q;
    assign bus.c_valid = c_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.c_row   = row;
    assign bus.c_data  = c_data_w;
    assign state_dbg   = state;

    // Job control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_ready_q <= 1'b0;
            c_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            row       <= '0;
            kcnt      <= '0;
            klen_q    <= '0;
            dcnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (k_eff == '0) begin
                            state  <= S_FIN;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_FEED;
                            a_ready_q <= 1'b1;
                            kcnt      <= '0;
                            klen_q    <= k_eff;
                        end
                    end
                end
                S_FEED: begin
                    if (bus.a_valid && a_ready_q) begin
                        kcnt <= kcnt + 1'b1;
                        if (kcnt + KW'(1) == klen_q) begin
                            state     <= S_DRAIN;
                            a_ready_q <= 1'b0;
                            dcnt      <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DRAIN_LAST) begin
                        state     <= S_OUT;
                        c_valid_q <= 1'b1;
                        row       <= '0;
                    end
                end
                S_OUT: begin
                    if (c_valid_q && bus.c_ready) begin
                        if (row == ROW_LAST) begin
                            state     <= S_FIN;
                            c_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand injection: live beat data while feeding, zeros while draining.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            inj_a[i] = (state == S_FEED) ? bus.a_data[i*DW +: DW] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            inj_b[j] = (state == S_FEED) ? bus.b_data[j*DW +: DW] : '0;
        end
    end

    // A-side skew: lane i passes through i stall-aware registers.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        if (i == 0) begin : g_direct
            assign edge_a[i] = inj_a[i];
        end else begin : g_delay
            logic signed [DW-1:0] sr [i];
            // Shift lane i on every array advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) sr[d] <= '0;
                end else if (clr) begin
                    for (int d = 0; d < i; d++) sr[d] <= '0;
                end else if (adv) begin
                    sr[0] <= inj_a[i];
                    for (int d = 1; d < i; d++) sr[d] <= sr[d-1];
                end
            end
            assign edge_a[i] = sr[i-1];
        end
    end

    // B-side skew: lane j passes through j stall-aware registers.
    for (genvar j = 0; j < COLS; j++) begin : g_skew_b
        if (j == 0) begin : g_direct
            assign edge_b[j] = inj_b[j];
        end else begin : g_delay
            logic signed [DW-1:0] sr [j];
            // Shift lane j on every array advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) sr[d] <= '0;
                end else if (clr) begin
                    for (int d = 0; d < j; d++) sr[d] <= '0;
                end else if (adv) begin
                    sr[0] <= inj_b[j];
                    for (int d = 1; d < j; d++) sr[d] <= sr[d-1];
                end
            end
            assign edge_b[j] = sr[j-1];
        end
    end

    // Cell inputs: array edge for the first column/row, neighbour pipe elsewhere.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_in[i][0] = edge_a[i];
            for (int j = 1; j < COLS; j++) a_in[i][j] = a_pipe[i][j-1];
        end
        for (int j = 0; j < COLS; j++) begin
            b_in[0][j] = edge_b[j];
            for (int i = 1; i < ROWS; i++) b_in[i][j] = b_pipe[i-1][j];
        end
    end

    // MAC cells: forward a right, b down, accumulate in place on each advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS - 1; j++) a_pipe[i][j] <= '0;
            for (int i = 0; i < ROWS - 1; i++)
                for (int j = 0; j < COLS; j++) b_pipe[i][j] <= '0;
        end else if (clr) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS - 1; j++) a_pipe[i][j] <= '0;
            for (int i = 0; i < ROWS - 1; i++)
                for (int j = 0; j < COLS; j++) b_pipe[i][j] <= '0;
        end else if (adv) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= acc[i][j] + mac_term(a_in[i][j], b_in[i][j]);
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS - 1; j++) a_pipe[i][j] <= a_in[i][j];
            for (int i = 0; i < ROWS - 1; i++)
                for (int j = 0; j < COLS; j++) b_pipe[i][j] <= b_in[i][j];
        end
    end

    // Row readout mux; zero whenever no row is being offered.
    always_comb begin
        c_data_w = '0;
        lane_val = '0;
        if (c_valid_q) begin
            for (int j = 0; j < COLS; j++) begin
                lane_val = acc[row][j];
`ifdef SYSTOLIC_RELU_EN
                if (lane_val[ACCW-1]) lane_val = '0;
`else
                lane_val = lane_val;
`endif
                c_data_w[j*ACCW +: ACCW] = lane_val;
            end
        end
    end
endmodule
